// File: rtl/exu_pkg.sv
// exu_pkg: op codes, FSM state type and MDU op classification shared by the execute unit.
`default_nettype none

package exu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'd0,
    OP_OR     = 5'd1,
    OP_XOR    = 5'd2,
    OP_ADD    = 5'd3,
    OP_SUB    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_EQU    = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op >= 5'd11) && (op <= 5'd18);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exu_mdu_iter.sv
// exu_mdu_iter: one-bit-per-step shift-add multiplier / restoring divider on operand magnitudes.
`default_nettype none

module exu_mdu_iter
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   hi_q, lo_q, opd_q, src1_q;
  logic [4:0]        op_q;
  logic              neg_q, rneg_q, dz_q;

  logic              a_sgn, b_sgn, is_div_q;
  logic [XLEN-1:0]   a_mag, b_mag, q_fix, r_fix;
  logic [XLEN:0]     shl, diff, sum;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    a_sgn = src1_i[XLEN-1] && (op_i == OP_MULH || op_i == OP_MULHSU ||
                               op_i == OP_DIV  || op_i == OP_REM);
    b_sgn = src2_i[XLEN-1] && (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
    a_mag = a_sgn ? -src1_i : src1_i;
    b_mag = b_sgn ? -src2_i : src2_i;
  end

  // hi holds the partial remainder (div) or upper product (mul); lo the quotient or multiplier.
  assign is_div_q = (op_q >= OP_DIV);
  assign shl      = {hi_q, lo_q[XLEN-1]};
  assign diff     = shl - {1'b0, opd_q};
  assign sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
  assign done_o   = step_i && (cnt_q == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
      src1_q <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= a_mag;
      opd_q  <= b_mag;
      src1_q <= src1_i;
      op_q   <= op_i;
      neg_q  <= a_sgn ^ b_sgn;
      rneg_q <= a_sgn;
      dz_q   <= (src2_i == '0);
    end else if (step_i) begin
      cnt_q <= done_o ? '0 : cnt_q + CW'(1);
      if (is_div_q) begin
        if (!diff[XLEN]) begin
          hi_q <= diff[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= shl[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi_q, lo_q} <= {sum, lo_q[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    q_fix    = neg_q ? -lo_q : lo_q;
    r_fix    = rneg_q ? -hi_q : hi_q;
    result_o = '0;
    case (op_q)
      OP_MUL:                        result_o = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_o = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result_o = dz_q ? '1 : q_fix;
      OP_REM, OP_REMU:               result_o = dz_q ? src1_q : r_fix;
      default:                       result_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/exu_pipe.sv
// exu_pipe: handshaked execute unit, single-cycle ALU into a registered result stage.
// Define EXU_MDU_EN to add the iterative multiply/divide path (otherwise MDU ops are illegal).
`default_nettype none

module exu_pipe
  import exu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int OP_W   = 5,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [OP_W-1:0]   in_op,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  input  logic              in_reg_wen,
  input  logic [REG_AW-1:0] in_reg_waddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_res,
  output logic              out_reg_wen,
  output logic [REG_AW-1:0] out_reg_waddr,
  output logic              out_illegal,
  output logic              busy
);

  localparam int SHW = $clog2(XLEN);

  state_e              state_q, state_d;
  logic                out_valid_q, out_wen_q, out_ill_q;
  logic [XLEN-1:0]     out_pc_q, out_res_q;
  logic [REG_AW-1:0]   out_waddr_q;

  logic                out_free, accept, op_hi_ok, mdu_sel, alu_ill;
  logic [4:0]          op5;
  logic [SHW-1:0]      sh;
  logic [XLEN-1:0]     alu_res;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = enable && (state_q == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign op5      = in_op[4:0];
  assign op_hi_ok = ((in_op >> 5) == '0);
  assign sh       = in_src2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    if (!op_hi_ok) begin
      alu_ill = 1'b1;
    end else begin
      case (op_e'(op5))
        OP_AND:  alu_res = in_src1 & in_src2;
        OP_OR:   alu_res = in_src1 | in_src2;
        OP_XOR:  alu_res = in_src1 ^ in_src2;
        OP_ADD:  alu_res = in_src1 + in_src2;
        OP_SUB:  alu_res = in_src1 - in_src2;
        OP_SLL:  alu_res = in_src1 << sh;
        OP_SRL:  alu_res = in_src1 >> sh;
        OP_SRA:  alu_res = $signed(in_src1) >>> sh;
        OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
        OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_src1 < in_src2)};
        OP_EQU:  alu_res = {{(XLEN-1){1'b0}}, (in_src1 == in_src2)};
        default: alu_ill = 1'b1;
      endcase
    end
  end

`ifdef EXU_MDU_EN
  logic              mdu_done;
  logic [XLEN-1:0]   mdu_res, pend_pc_q;
  logic              pend_wen_q;
  logic [REG_AW-1:0] pend_waddr_q;

  assign mdu_sel = op_hi_ok && is_mdu_op(op5);

  exu_mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && mdu_sel),
    .step_i   (enable && (state_q == ST_ITER)),
    .op_i     (op5),
    .src1_i   (in_src1),
    .src2_i   (in_src2),
    .done_o   (mdu_done),
    .result_o (mdu_res)
  );

  // Tags wait here so the out register can keep presenting the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_pc_q    <= '0;
      pend_wen_q   <= 1'b0;
      pend_waddr_q <= '0;
    end else if (accept && mdu_sel) begin
      pend_pc_q    <= in_pc;
      pend_wen_q   <= in_reg_wen;
      pend_waddr_q <= in_reg_waddr;
    end
  end
`else
  assign mdu_sel = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
`ifdef EXU_MDU_EN
    case (state_q)
      ST_IDLE: if (accept && mdu_sel)     state_d = ST_ITER;
      ST_ITER: if (mdu_done)              state_d = ST_HOLD;
      ST_HOLD: if (enable && out_free)    state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_res_q   <= '0;
      out_wen_q   <= 1'b0;
      out_waddr_q <= '0;
      out_ill_q   <= 1'b0;
    end else if (accept && !mdu_sel) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= in_pc;
      out_res_q   <= alu_res;
      out_wen_q   <= in_reg_wen;
      out_waddr_q <= in_reg_waddr;
      out_ill_q   <= alu_ill;
`ifdef EXU_MDU_EN
    end else if ((state_q == ST_HOLD) && enable && out_free) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= pend_pc_q;
      out_res_q   <= mdu_res;
      out_wen_q   <= pend_wen_q;
      out_waddr_q <= pend_waddr_q;
      out_ill_q   <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_res       = out_res_q;
  assign out_reg_wen   = out_wen_q;
  assign out_reg_waddr = out_waddr_q;
  assign out_illegal   = out_ill_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_exu_pipe.sv
// tb_exu_pipe: scoreboard bench for exu_pipe; MDU checks are built when EXU_MDU_EN is defined.
`default_nettype none

module tb_exu_pipe;
  import exu_pkg::*;

  localparam int XLEN = 32;
  localparam int OP_W = 5;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n, enable, in_valid, in_ready, in_reg_wen;
  logic [XLEN-1:0]   in_pc, in_src1, in_src2;
  logic [OP_W-1:0]   in_op;
  logic [REG_AW-1:0] in_reg_waddr;
  logic              out_valid, out_ready, out_reg_wen, out_illegal, busy;
  logic [XLEN-1:0]   out_pc, out_res;
  logic [REG_AW-1:0] out_reg_waddr;

  exu_pipe #(.XLEN(XLEN), .OP_W(OP_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_reg_wen(in_reg_wen), .in_reg_waddr(in_reg_waddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_res(out_res),
    .out_reg_wen(out_reg_wen), .out_reg_waddr(out_reg_waddr),
    .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   res;
    logic              wen;
    logic [REG_AW-1:0] waddr;
    logic              ill;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill);
    longint      sp;
    logic [63:0] up;
    int          ia, ib;
    ia = a;
    ib = b;
    r = '0;
    ill = 1'b0;
    case (op)
      5'd0:  r = a & b;
      5'd1:  r = a | b;
      5'd2:  r = a ^ b;
      5'd3:  r = a + b;
      5'd4:  r = a - b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $signed(a) >>> b[4:0];
      5'd8:  r = (ia < ib) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: r = (a == b) ? 32'd1 : 32'd0;
`ifdef EXU_MDU_EN
      5'd11: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
      5'd12: begin sp = longint'(ia) * longint'(ib); r = sp[63:32]; end
      5'd13: begin sp = longint'(ia) * longint'({32'b0, b}); r = sp[63:32]; end
      5'd14: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      5'd15: if (b == 0) r = '1;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
             else r = ia / ib;
      5'd16: r = (b == 0) ? '1 : a / b;
      5'd17: if (b == 0) r = a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
             else r = ia % ib;
      5'd18: r = (b == 0) ? a : a % b;
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Transfer is committed at the next rising edge; compare against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res", out_res, e.res);
        check("pc", out_pc, e.pc);
        check("tag", {out_reg_wen, out_reg_waddr}, {e.wen, e.waddr});
        check("illegal", out_illegal, e.ill);
      end
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   w;
    in_valid     = 1'b1;
    in_op        = op;
    in_src1      = a;
    in_src2      = b;
    in_pc        = $urandom;
    in_reg_wen   = 1'($urandom);
    in_reg_waddr = 5'($urandom);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(w), 64'd0);
      in_valid = 1'b0;
      return;
    end
    model(op, a, b, e.res, e.ill);
    e.pc = in_pc;
    e.wen = in_reg_wen;
    e.waddr = in_reg_waddr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 200);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          t1, n, w;
    logic [31:0] held;
    logic [4:0]  op;

    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_op = '0; in_src1 = '0; in_src2 = '0; in_reg_wen = 1'b0; in_reg_waddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res", out_res, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_ill", out_illegal, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    check("add_latency", out_valid, 1'b1);
    check("add_wrap", out_res, 32'h0);

    send(OP_SRA, 32'h8000_0000, 32'd33);
    t1 = acc_cyc;
    send(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    check("b2b_gap", 64'(acc_cyc - t1), 64'd1);

    out_ready = 1'b0;
    held = out_res;
    check("bp_slt", held, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_hold", out_res, held);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drained", out_valid, 1'b0);

    enable = 1'b0;
    @(negedge clk);
    check("frozen_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    enable = 1'b1;

    send(5'd31, 32'h1234_5678, 32'h1);
    check("op31_ill", out_illegal, 1'b1);
    check("op31_res", out_res, 32'h0);
    send(OP_MUL, 32'd6, 32'd7);

`ifdef EXU_MDU_EN
    send(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_out(n);
    check("div_latency", 64'(n), 64'(XLEN + 1));
    check("div_res", out_res, 32'hFFFF_FFFD);
    send(OP_REM, 32'd5, 32'd0);
    wait_out(n);
    check("rem_dz", out_res, 32'd5);
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_out(n);
    check("div_ovf", out_res, 32'h8000_0000);
    send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) begin @(posedge clk); #1; end
    check("iter_busy", busy, 1'b1);
    check("iter_ready", in_ready, 1'b0);
    enable = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    enable = 1'b1;
    wait_out(n);
    check("stall_latency", 64'(n + 9), 64'(XLEN + 5));
    check("mulhu_res", out_res, 32'hFFFF_FFFE);
`endif

    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(19, 31));
      else                          op = 5'($urandom_range(0, 18));
      send(op, rnd_val(), rnd_val());
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;

`ifdef EXU_MDU_EN
    send(OP_DIV, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy, 1'b1);
`else
    out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2);
    check("pre_rst_valid", out_valid, 1'b1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_valid", out_valid, 1'b0);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(OP_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000);
    check("post_rst_res", out_res, 32'h5A5A_0F0F);
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_final", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
